// File: rtl/arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN, GAP} arb_state_t;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = $clog2(MAX_REQ);

  // Binary index of the set bit in a one-hot (or zero) vector.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_REQ); i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first requester above the last winner.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] winner,
  output logic             valid
);

  logic [SEL_W-1:0] idx;

  // Scan from farthest to nearest so the nearest set bit after last wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = int'(N); i >= 1; i--) begin
      idx = SEL_W'((int'(last) + i) % int'(N));
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the shared memory/register-write port with hold timeout.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned SEL_W    = $clog2(N),
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [N-1:0]     grant_d;
  logic [SEL_W-1:0] sel_d;
  logic             busy_d;
  logic             timeout_d;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_valid;
  logic [SEL_W-1:0] owner;

  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign owner = SEL_W'(onehot_to_idx(MAX_REQ'(grant)));

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    grant_d   = grant;
    sel_d     = sel;
    busy_d    = busy;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (pick_valid) begin
          grant_d = N'(1) << pick_idx;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          last_d  = pick_idx;
          cnt_d   = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // done outranks the hold limit, so a coinciding timeout is suppressed
        if (done || !req[owner] || cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          timeout_d = !done && req[owner];
          grant_d   = '0;
          busy_d    = 1'b0;
          state_d   = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SEL_W'(N - 1);
      grant   <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant   <= grant_d;
      sel     <= sel_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

endmodule
